// File: rtl/dec_pkg.sv
// Shared decoder definitions: default select width and the one-hot helper.
package dec_pkg;

  localparam int unsigned DEC_SEL_W = 3;
  localparam int unsigned DEC_OUT_W = 1 << DEC_SEL_W;

  // Decode sel to a one-hot word; the enable gates first, so sel is ignored when en=0.
  function automatic logic [DEC_OUT_W-1:0] onehot_f(input logic [DEC_SEL_W-1:0] sel,
                                                    input logic                 en);
    logic [DEC_OUT_W-1:0] word;
    word = '0;
    if (en) begin
      word[sel] = 1'b1;
    end
    return word;
  endfunction

endpackage

// File: rtl/dec_core.sv
// Combinational SEL_W -> 2**SEL_W one-hot decoder with enable.
//   en     decode enable, active-high
//   in     binary select code
//   out_c  one-hot result, all zeros when en=0
module dec_core
  import dec_pkg::*;
#(
  parameter int unsigned SEL_W = DEC_SEL_W
) (
  input  logic                    en,
  input  logic [SEL_W-1:0]        in,
  output logic [(1 << SEL_W)-1:0] out_c
);

  localparam int unsigned OUT_W = 1 << SEL_W;

  generate
    if (SEL_W == DEC_SEL_W) begin : g_pkg
      // Default width reuses the shared helper.
      assign out_c = onehot_f(in, en);
    end else begin : g_generic
      // Bit i is set only when enabled and in equals i; en is ANDed so an
      // unknown code cannot leak through while disabled.
      always_comb begin
        out_c = '0;
        for (int unsigned i = 0; i < OUT_W; i++) begin
          out_c[i] = en & (in == SEL_W'(i));
        end
      end
    end
  endgenerate

endmodule

// File: rtl/decoder_3to8.sv
// Binary-to-one-hot decoder with enable and optional output register.
//   clk  system clock, rising edge
//   rst  synchronous reset, active-high (only used when REG_OUT=1)
//   en   decode enable, active-high
//   in   binary select code
//   out  one-hot decode; registered (1-cycle latency) when REG_OUT=1,
//        combinational when REG_OUT=0
module decoder_3to8
  import dec_pkg::*;
#(
  parameter int unsigned SEL_W   = DEC_SEL_W,
  parameter bit          REG_OUT = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic [SEL_W-1:0]        in,
  output logic [(1 << SEL_W)-1:0] out
);

  localparam int unsigned OUT_W = 1 << SEL_W;

  logic [OUT_W-1:0] dec_c;

  dec_core #(
    .SEL_W (SEL_W)
  ) u_core (
    .en    (en),
    .in    (in),
    .out_c (dec_c)
  );

  generate
    if (REG_OUT) begin : g_reg
      // Output flop; reset has priority over any decode.
      always_ff @(posedge clk) begin
        if (rst) begin
          out <= '0;
        end else begin
          out <= dec_c;
        end
      end
    end else begin : g_comb
      // Pass-through; clk and rst are kept on the port list but unused here.
      logic unused_clk_rst;
      assign unused_clk_rst = &{1'b0, clk, rst};
      assign out = dec_c;
    end
  endgenerate

endmodule

// File: tb/tb_decoder_3to8.sv
// Self-checking bench for decoder_3to8: registered and combinational builds.
module tb_decoder_3to8;

  logic       clk;
  logic       rst;
  logic       en;
  logic [2:0] in;
  logic [7:0] out;
  logic [7:0] out_c;

  int unsigned checks;
  int unsigned errors;

  logic [7:0] exp_q;
  bit         exp_valid;

  decoder_3to8 #(.SEL_W(3), .REG_OUT(1'b1)) dut (
    .clk (clk),
    .rst (rst),
    .en  (en),
    .in  (in),
    .out (out)
  );

  decoder_3to8 #(.SEL_W(3), .REG_OUT(1'b0)) dut_c (
    .clk (clk),
    .rst (rst),
    .en  (en),
    .in  (in),
    .out (out_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference decode: a shifted 1 when enabled, zero otherwise.
  function automatic logic [7:0] ref_dec(input bit e, input int unsigned code);
    return e ? 8'(32'd1 << code) : 8'h00;
  endfunction

  // Registered-build model: value seen at an edge appears after it, reset wins.
  always @(posedge clk) begin
    exp_q     <= rst ? 8'h00 : ref_dec(en, int'(in));
    exp_valid <= 1'b1;
  end

  // Per-cycle comparison of both builds against the model.
  always @(negedge clk) begin
    if (exp_valid) begin
      checks++;
      if (out !== exp_q) begin
        errors++;
        $display("FAIL reg_out t=%0t: got %h, expected %h", $time, out, exp_q);
      end
      checks++;
      if ($countones(out) > 1) begin
        errors++;
        $display("FAIL onehot t=%0t: got %h, expected at most one bit set", $time, out);
      end
    end
    checks++;
    if (out_c !== ref_dec(en, int'(in))) begin
      errors++;
      $display("FAIL comb_out t=%0t: got %h, expected %h", $time, out_c,
               ref_dec(en, int'(in)));
    end
  end

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, expv);
    end
  endtask

  // Apply inputs shortly after a falling edge, then wait through the next rising edge.
  task automatic step(input bit r, input bit e, input logic [2:0] code);
    #1;
    rst = r;
    en  = e;
    in  = code;
    @(posedge clk);
    @(negedge clk);
  endtask

  logic [7:0] sweep_exp [8];

  initial begin
    checks    = 0;
    errors    = 0;
    exp_valid = 1'b0;
    rst       = 1'b1;
    en        = 1'b1;
    in        = 3'd5;
    sweep_exp = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};
    @(negedge clk);

    // Reset held over two edges with a live code, then released.
    step(1'b1, 1'b1, 3'd5);
    chk("reset_edge1", out, 8'h00);
    step(1'b1, 1'b1, 3'd5);
    chk("reset_edge2", out, 8'h00);
    step(1'b0, 1'b1, 3'd5);
    chk("reset_release", out, 8'h20);

    // Disabled sweep.
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 1'b0, 3'(i));
      chk("disabled_sweep", out, 8'h00);
    end

    // Enabled sweep, one code per cycle.
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 1'b1, 3'(i));
      chk("enabled_sweep", out, sweep_exp[i]);
    end

    // Steady top code, then disable.
    step(1'b0, 1'b1, 3'd7);
    chk("steady_7", out, 8'h80);
    step(1'b0, 1'b0, 3'd7);
    chk("disable_after_7", out, 8'h00);

    // Mid-sweep reset pulse.
    step(1'b0, 1'b1, 3'd1);
    chk("pre_pulse", out, 8'h02);
    step(1'b1, 1'b1, 3'd3);
    chk("rst_pulse", out, 8'h00);
    step(1'b0, 1'b1, 3'd3);
    chk("post_pulse", out, 8'h08);

    // Combinational build responds with no clock edge in between.
    #1;
    en = 1'b1;
    in = 3'd2;
    #1;
    chk("comb_en_2", out_c, 8'h04);
    en = 1'b0;
    #1;
    chk("comb_dis", out_c, 8'h00);

    // Randomized traffic with occasional reset pulses.
    for (int n = 0; n < 400; n++) begin
      step(($urandom_range(15) == 0), ($urandom_range(3) != 0), 3'($urandom_range(7)));
    end

    step(1'b0, 1'b0, 3'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
